// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank arbiter: JK operation codes,
// owner encodings and the arbitration state type.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  // State values double as the owner output encoding.
  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_LOCK_A = 2'b01,
    ST_LOCK_B = 2'b10
  } arb_state_e;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with a clock enable and synchronous active-low reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  // JK next-state: hold, clear, set or invert when enabled.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Two-port round-robin arbiter with optional lock sharing a bank of JK
// cells; each granted request applies one JK op to a masked set of bits.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             a_valid,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_mask,
  input  logic             a_lock,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_mask,
  input  logic             b_lock,
  output logic             b_ready,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  arb_state_e       r_state;
  logic             r_rr;
  logic [CNT_W-1:0] r_a_count;
  logic [CNT_W-1:0] r_b_count;

  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_a_xfer;
  logic             w_b_xfer;
  logic             w_xfer;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_q;

  // Grant decode from state, round-robin pointer and both valids only.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    case (r_state)
      ST_FREE: begin
        w_a_ready = a_valid && (!b_valid || (r_rr == RR_A));
        w_b_ready = b_valid && (!a_valid || (r_rr == RR_B));
      end
      ST_LOCK_A: begin
        w_a_ready = a_valid;
        w_b_ready = 1'b0;
      end
      ST_LOCK_B: begin
        w_a_ready = 1'b0;
        w_b_ready = b_valid;
      end
      default: begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
      end
    endcase
  end

  assign w_a_xfer = a_valid && w_a_ready;
  assign w_b_xfer = b_valid && w_b_ready;
  assign w_xfer   = w_a_xfer || w_b_xfer;

  // Route the granted port's operation to the bank.
  always_comb begin
    if (w_a_xfer) begin
      w_op   = a_op;
      w_mask = a_mask;
    end else if (w_b_xfer) begin
      w_op   = b_op;
      w_mask = b_mask;
    end else begin
      w_op   = JK_HOLD;
      w_mask = {WIDTH{1'b0}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .res (res),
        .en  (w_mask[gi] && w_xfer),
        .j   (w_op[1]),
        .k   (w_op[0]),
        .q   (w_q[gi])
      );
    end
  endgenerate

  // Arbitration FSM: free round-robin, or a port holding the lock.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= ST_FREE;
      r_rr    <= RR_A;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (w_a_xfer) begin
            r_rr    <= RR_B;
            r_state <= a_lock ? ST_LOCK_A : ST_FREE;
          end else if (w_b_xfer) begin
            r_rr    <= RR_A;
            r_state <= b_lock ? ST_LOCK_B : ST_FREE;
          end else begin
            r_rr    <= r_rr;
            r_state <= r_state;
          end
        end
        ST_LOCK_A: begin
          if (!a_valid || !a_lock) begin
            r_state <= ST_FREE;
            r_rr    <= RR_B;
          end else begin
            r_state <= r_state;
            r_rr    <= r_rr;
          end
        end
        ST_LOCK_B: begin
          if (!b_valid || !b_lock) begin
            r_state <= ST_FREE;
            r_rr    <= RR_A;
          end else begin
            r_state <= r_state;
            r_rr    <= r_rr;
          end
        end
        default: begin
          r_state <= ST_FREE;
          r_rr    <= RR_A;
        end
      endcase
    end
  end

  // Saturating per-port transfer counters.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_a_count <= {CNT_W{1'b0}};
      r_b_count <= {CNT_W{1'b0}};
    end else begin
      if (w_a_xfer && (r_a_count != {CNT_W{1'b1}})) begin
        r_a_count <= r_a_count + CNT_W'(1);
      end else begin
        r_a_count <= r_a_count;
      end
      if (w_b_xfer && (r_b_count != {CNT_W{1'b1}})) begin
        r_b_count <= r_b_count + CNT_W'(1);
      end else begin
        r_b_count <= r_b_count;
      end
    end
  end

  assign a_ready = w_a_ready;
  assign b_ready = w_b_ready;
  assign q       = w_q;
  assign owner   = r_state;
  assign a_count = r_a_count;
  assign b_count = r_b_count;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbiter.
module tb_jk_bank_arbiter;

  logic       clk;
  logic       res;
  logic       a_valid, a_lock, b_valid, b_lock;
  logic [1:0] a_op, b_op;
  logic [7:0] a_mask, b_mask;

  logic        a_ready1, b_ready1, a_ready2, b_ready2;
  logic [7:0]  q1, q2;
  logic [1:0]  owner1, owner2;
  logic [15:0] ac1, bc1;
  logic [1:0]  ac2, bc2;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Behavioural model state: owner 0 none, 1 A, 2 B; rr 0 means A first.
  logic [7:0] m_q = 8'h00;
  int m_own = 0;
  int m_rr = 0;
  int m_ca = 0, m_cb = 0, m_ca2 = 0, m_cb2 = 0;

  jk_bank_arbiter #(.WIDTH(8), .CNT_W(16)) dut1 (
    .clk(clk), .res(res),
    .a_valid(a_valid), .a_op(a_op), .a_mask(a_mask), .a_lock(a_lock), .a_ready(a_ready1),
    .b_valid(b_valid), .b_op(b_op), .b_mask(b_mask), .b_lock(b_lock), .b_ready(b_ready1),
    .q(q1), .owner(owner1), .a_count(ac1), .b_count(bc1)
  );

  jk_bank_arbiter #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .res(res),
    .a_valid(a_valid), .a_op(a_op), .a_mask(a_mask), .a_lock(a_lock), .a_ready(a_ready2),
    .b_valid(b_valid), .b_op(b_op), .b_mask(b_mask), .b_lock(b_lock), .b_ready(b_ready2),
    .q(q2), .owner(owner2), .a_count(ac2), .b_count(bc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which port the rules grant right now: 0 none, 1 A, 2 B.
  function automatic int exp_grant();
    if (m_own == 1) return a_valid ? 1 : 0;
    if (m_own == 2) return b_valid ? 2 : 0;
    if (a_valid && b_valid) return (m_rr == 0) ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] apply_op(input logic [7:0] cur, input logic [1:0] op,
                                          input logic [7:0] msk);
    case (op)
      2'b01:   return cur & ~msk;
      2'b10:   return cur | msk;
      2'b11:   return cur ^ msk;
      default: return cur;
    endcase
  endfunction

  function automatic int sat_inc(input int c, input int mx);
    return (c < mx) ? c + 1 : mx;
  endfunction

  // Model update on each clock edge.
  always @(posedge clk) begin
    if (!res) begin
      m_q <= 8'h00; m_own <= 0; m_rr <= 0;
      m_ca <= 0; m_cb <= 0; m_ca2 <= 0; m_cb2 <= 0;
    end else begin
      case (exp_grant())
        1: begin
          m_q   <= apply_op(m_q, a_op, a_mask);
          m_ca  <= sat_inc(m_ca, 65535);
          m_ca2 <= sat_inc(m_ca2, 3);
          if (m_own == 0) begin
            m_rr  <= 1;
            m_own <= a_lock ? 1 : 0;
          end else if (!a_lock) begin
            m_own <= 0;
            m_rr  <= 1;
          end
        end
        2: begin
          m_q   <= apply_op(m_q, b_op, b_mask);
          m_cb  <= sat_inc(m_cb, 65535);
          m_cb2 <= sat_inc(m_cb2, 3);
          if (m_own == 0) begin
            m_rr  <= 0;
            m_own <= b_lock ? 2 : 0;
          end else if (!b_lock) begin
            m_own <= 0;
            m_rr  <= 0;
          end
        end
        default: begin
          if (m_own != 0) begin
            m_rr  <= (m_own == 1) ? 1 : 0;
            m_own <= 0;
          end
        end
      endcase
    end
  end

  // Compare both DUTs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ready",  a_ready1, (exp_grant() == 1) ? 1 : 0);
      chk("b_ready",  b_ready1, (exp_grant() == 2) ? 1 : 0);
      chk("q",        q1, m_q);
      chk("owner",    owner1, m_own);
      chk("a_count",  ac1, m_ca);
      chk("b_count",  bc1, m_cb);
      chk("a_ready2", a_ready2, (exp_grant() == 1) ? 1 : 0);
      chk("b_ready2", b_ready2, (exp_grant() == 2) ? 1 : 0);
      chk("q2",       q2, m_q);
      chk("owner2",   owner2, m_own);
      chk("a_count2", ac2, m_ca2);
      chk("b_count2", bc2, m_cb2);
    end
  end

  task automatic drv(input logic av, input logic [1:0] aop, input logic [7:0] am, input logic al,
                     input logic bv, input logic [1:0] bop, input logic [7:0] bm, input logic bl);
    a_valid = av; a_op = aop; a_mask = am; a_lock = al;
    b_valid = bv; b_op = bop; b_mask = bm; b_lock = bl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] tgl_seq;
  int sat_seq[5];

  initial begin
    tgl_seq = 5'b10101;
    sat_seq = '{1, 2, 3, 3, 3};
    res = 1'b0;
    drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    nxt();
    chk_en = 1'b1;

    // Reset state, then a lone A set of the low nibble.
    @(negedge clk);
    chk("rst_q", q1, 8'h00);
    chk("rst_owner", owner1, 2'b00);
    chk("rst_a_count", ac1, 16'd0);
    nxt(); res = 1'b1;
    drv(1'b1, 2'b10, 8'h0F, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_a_ready", a_ready1, 1'b1);
    nxt(); drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    chk("t1_q", q1, 8'h0F);
    chk("t1_a_count", ac1, 16'd1);
    chk("t1_b_count", bc1, 16'd0);

    // Both valid from reset: A first, then B.
    nxt(); res = 1'b0;
    nxt(); res = 1'b1;
    drv(1'b1, 2'b11, 8'hFF, 1'b0, 1'b1, 2'b01, 8'h01, 1'b0);
    @(negedge clk);
    chk("t2_c1_a_ready", a_ready1, 1'b1);
    chk("t2_c1_b_ready", b_ready1, 1'b0);
    nxt();
    @(negedge clk);
    chk("t2_c2_b_ready", b_ready1, 1'b1);
    chk("t2_c2_a_ready", a_ready1, 1'b0);
    chk("t2_c2_q", q1, 8'hFF);
    nxt(); drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    chk("t2_q", q1, 8'hFE);
    chk("t2_a_count", ac1, 16'd1);
    chk("t2_b_count", bc1, 16'd1);

    // A takes the lock for three transfers while B waits.
    nxt(); drv(1'b1, 2'b10, 8'h01, 1'b1, 1'b1, 2'b01, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t3_l1_b_ready", b_ready1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nxt();
      @(negedge clk);
      chk("t3_lock_owner", owner1, 2'b01);
      chk("t3_lock_b_ready", b_ready1, 1'b0);
    end
    nxt(); drv(1'b1, 2'b10, 8'h01, 1'b0, 1'b1, 2'b01, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t3_rel_a_ready", a_ready1, 1'b1);
    nxt();
    @(negedge clk);
    chk("t3_free_owner", owner1, 2'b00);
    chk("t3_free_b_ready", b_ready1, 1'b1);
    chk("t3_free_a_ready", a_ready1, 1'b0);

    // Toggle bit 7 repeatedly; CNT_W=2 counter saturates at 3.
    nxt(); res = 1'b0;
    drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    nxt(); res = 1'b1;
    drv(1'b1, 2'b11, 8'h80, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      @(negedge clk);
      chk("t4_q7", q1[7], tgl_seq[k]);
      chk("t5_sat", ac2, sat_seq[k]);
    end

    // Reset while B holds the lock with a request pending.
    nxt(); drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 2'b10, 8'h01, 1'b1);
    nxt(); drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 2'b10, 8'hFF, 1'b1);
    @(negedge clk);
    chk("t6_owner_b", owner1, 2'b10);
    nxt(); res = 1'b0;
    @(negedge clk);
    chk("t6_q_pre", q1, 8'hFF);
    nxt(); res = 1'b1;
    drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    chk("t6_q", q1, 8'h00);
    chk("t6_owner", owner1, 2'b00);
    chk("t6_b_count", bc1, 16'd0);

    // Random traffic, including occasional resets and empty masks.
    for (int n = 0; n < 3000; n++) begin
      nxt();
      res     = ($urandom_range(0, 63) != 0);
      a_valid = ($urandom_range(0, 2) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_op    = 2'($urandom_range(0, 3));
      b_op    = 2'($urandom_range(0, 3));
      a_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      a_lock  = ($urandom_range(0, 1) != 0);
      b_lock  = ($urandom_range(0, 1) != 0);
    end
    nxt();
    drv(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
